// File: rtl/note_freq_arbiter.sv
// ---------------------------------------------------------------------------
// note_freq_arbiter
//
// Shares one combinational note->frequency table among N_REQ requesters.
// A round-robin arbiter picks one pending requester, registers its note
// onto the table address (lut_note), captures the table result one cycle
// later and presents it for one cycle together with a per-requester ack.
//
// Timing per grant (fixed):
//   cycle T   : IDLE, req seen -> winner and note registered
//   cycle T+1 : LOOKUP, lut_freq captured into freq_out/freq_id
//   cycle T+2 : RESP, freq_valid=1 and ack[winner]=1, ptr advanced
//
// Ports
//   clk        : clock, rising edge
//   rst_n      : synchronous active-low reset
//   req        : per-requester lookup request (level, held until ack)
//   req_note   : packed notes, requester i at [i*NOTE_W +: NOTE_W]
//   ack        : one-cycle completion pulse for the served requester
//   lut_note   : registered note driven to the shared table
//   lut_freq   : combinational table result for lut_note
//   freq_out   : registered frequency (x32 fixed point)
//   freq_id    : requester index that freq_out belongs to
//   freq_valid : one-cycle strobe marking freq_out/freq_id as new
//   busy       : high whenever a lookup is in progress
// ---------------------------------------------------------------------------
module note_freq_arbiter #(
    parameter  int N_REQ  = 4,
    parameter  int NOTE_W = 7,
    parameter  int FREQ_W = 20,
    localparam int ID_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*NOTE_W-1:0] req_note,
    output logic [N_REQ-1:0]        ack,
    output logic [NOTE_W-1:0]       lut_note,
    input  logic [FREQ_W-1:0]       lut_freq,
    output logic [FREQ_W-1:0]       freq_out,
    output logic [ID_W-1:0]         freq_id,
    output logic                    freq_valid,
    output logic                    busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        RESP   = 2'd2
    } state_e;

    // Wide-by-one constants so the modulo arithmetic below stays width-clean.
    localparam logic [ID_W:0]   NREQ_W = (ID_W+1)'(N_REQ);
    localparam logic [ID_W-1:0] LAST_ID = ID_W'(N_REQ - 1);

    state_e                       state_q;
    logic [ID_W-1:0]              ptr_q;
    logic [ID_W-1:0]              win_q;
    logic [NOTE_W-1:0]            lut_note_q;
    logic [FREQ_W-1:0]            freq_out_q;
    logic [ID_W-1:0]              freq_id_q;
    logic                         freq_valid_q;
    logic [N_REQ-1:0]             ack_q;

    logic [N_REQ-1:0][NOTE_W-1:0] note_arr;
    logic [ID_W-1:0]              pick;
    logic                         any_req;
    logic [N_REQ-1:0]             ack_d;
    logic [ID_W-1:0]              ptr_d;

    assign note_arr = req_note;

    // Round-robin search ptr, ptr+1, ... (mod N_REQ). Walking the offsets
    // from the far end down lets the nearest requester overwrite the rest,
    // so the final pick is the first requester at or after ptr.
    always_comb begin
        logic [ID_W:0] sum;
        pick    = ptr_q;
        any_req = 1'b0;
        sum     = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            sum = {1'b0, ptr_q} + (ID_W+1)'(k);
            if (sum >= NREQ_W) begin
                sum = sum - NREQ_W;
            end
            if (req[sum[ID_W-1:0]]) begin
                pick    = sum[ID_W-1:0];
                any_req = 1'b1;
            end
        end
    end

    // One-hot ack for the current winner, loaded into ack_q on the
    // LOOKUP->RESP edge so it is visible exactly during RESP.
    always_comb begin
        ack_d        = '0;
        ack_d[win_q] = 1'b1;
    end

    // Pointer moves just past the winner, wrapping at N_REQ-1.
    always_comb begin
        ptr_d = (win_q == LAST_ID) ? '0 : win_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            win_q        <= '0;
            lut_note_q   <= '0;
            freq_out_q   <= '0;
            freq_id_q    <= '0;
            freq_valid_q <= 1'b0;
            ack_q        <= '0;
        end else begin
            // Strobes are single-cycle by default.
            freq_valid_q <= 1'b0;
            ack_q        <= '0;
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        win_q      <= pick;
                        lut_note_q <= note_arr[pick];
                        state_q    <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    // Table output settles from lut_note_q within this cycle.
                    freq_out_q   <= lut_freq;
                    freq_id_q    <= win_q;
                    freq_valid_q <= 1'b1;
                    ack_q        <= ack_d;
                    state_q      <= RESP;
                end
                RESP: begin
                    ptr_q   <= ptr_d;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ack        = ack_q;
    assign lut_note   = lut_note_q;
    assign freq_out   = freq_out_q;
    assign freq_id    = freq_id_q;
    assign freq_valid = freq_valid_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_note_freq_arbiter.sv
// ---------------------------------------------------------------------------
// tb_note_freq_arbiter
//
// Directed scenarios with hand-known frequencies plus a randomized phase.
// Every cycle all outputs are compared against a transaction-level model:
// a grant is taken from the requests present at an idle edge, the result
// appears two cycles later, and the pointer moves past the winner one
// cycle after that. The frequency table is an equal-tempered A4=440 Hz
// table (x32) computed by the bench.
// ---------------------------------------------------------------------------
module tb_note_freq_arbiter;

    localparam int N  = 4;
    localparam int NW = 7;
    localparam int FW = 20;

    logic             clk;
    logic             rst_n;
    logic [N-1:0]     req;
    logic [N-1:0][NW-1:0] note_arr;
    logic [N*NW-1:0]  req_note;
    logic [N-1:0]     ack;
    logic [NW-1:0]    lut_note;
    logic [FW-1:0]    lut_freq;
    logic [FW-1:0]    freq_out;
    logic [1:0]       freq_id;
    logic             freq_valid;
    logic             busy;

    logic [FW-1:0]    lut_tab [0:127];

    int n_chk;
    int n_fail;

    // model state
    int           m_ptr;
    bit           m_busy;
    int           m_age;
    int           m_win;
    logic [N-1:0] exp_ack;
    logic         exp_valid;
    logic [FW-1:0] exp_freq;
    logic [1:0]   exp_id;
    logic [NW-1:0] exp_lut;

    assign req_note = note_arr;
    assign lut_freq = lut_tab[lut_note];

    note_freq_arbiter #(.N_REQ(N), .NOTE_W(NW), .FREQ_W(FW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .req_note   (req_note),
        .ack        (ack),
        .lut_note   (lut_note),
        .lut_freq   (lut_freq),
        .freq_out   (freq_out),
        .freq_id    (freq_id),
        .freq_valid (freq_valid),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance the model by one edge using the inputs the DUT is about to sample.
    task automatic model_step();
        if (!rst_n) begin
            m_ptr = 0; m_busy = 0; m_age = 0; m_win = 0;
            exp_ack = '0; exp_valid = 0; exp_freq = '0; exp_id = '0; exp_lut = '0;
        end else begin
            exp_ack   = '0;
            exp_valid = 1'b0;
            if (!m_busy) begin
                if (req != '0) begin
                    for (int k = 0; k < N; k++) begin
                        int i;
                        i = (m_ptr + k) % N;
                        if (req[i]) begin
                            m_win = i;
                            break;
                        end
                    end
                    exp_lut = note_arr[m_win];
                    m_busy  = 1;
                    m_age   = 1;
                end
            end else if (m_age == 1) begin
                exp_freq       = lut_tab[exp_lut];
                exp_id         = 2'(m_win);
                exp_valid      = 1'b1;
                exp_ack[m_win] = 1'b1;
                m_age          = 2;
            end else begin
                m_ptr  = (m_win + 1) % N;
                m_busy = 0;
                m_age  = 0;
            end
        end
    endtask

    task automatic check_all();
        chk("ack",      ack,        exp_ack);
        chk("valid",    freq_valid, exp_valid);
        chk("freq_out", freq_out,   exp_freq);
        chk("freq_id",  freq_id,    exp_id);
        chk("busy",     busy,       m_busy);
        chk("lut_note", lut_note,   exp_lut);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic one_req(input int idx, input logic [NW-1:0] note, input logic [FW-1:0] f);
        req = '0;
        req[idx] = 1'b1;
        note_arr[idx] = note;
        tick();
        chk("one_lut_note", lut_note, note);
        chk("one_busy", busy, 1);
        tick();
        chk("one_valid", freq_valid, 1);
        chk("one_freq", freq_out, f);
        chk("one_id", freq_id, idx);
        chk("one_ack", ack, 1 << idx);
        req = '0;
        tick();
        chk("one_valid_off", freq_valid, 0);
        chk("one_ack_off", ack, 0);
        chk("one_freq_hold", freq_out, f);
        chk("one_idle", busy, 0);
    endtask

    initial begin
        int acks_seen;
        int ack_who [5];
        int ack_cyc [5];

        for (int n = 0; n < 128; n++) begin
            lut_tab[n] = FW'($rtoi(14080.0 * $pow(2.0, (real'(n) - 57.0) / 12.0) + 0.5));
        end
        n_chk = 0; n_fail = 0;
        rst_n = 1'b0; req = '0; note_arr = '0;
        repeat (3) tick();
        chk("rst_freq", freq_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ack", ack, 0);
        rst_n = 1'b1;

        // single request and boundary notes
        one_req(0, 7'h39, 20'h03700);
        one_req(0, 7'h00, 20'h0020B);
        one_req(1, 7'h7F, 20'hC3FF7);

        // note changed after grant has no effect
        req = 4'b0100; note_arr[2] = 7'h30;
        tick();
        note_arr[2] = 7'h45;
        tick();
        chk("late_freq", freq_out, 20'h020B4);
        chk("late_id", freq_id, 2);
        req = '0;
        tick();

        // early drop still completes
        req = 4'b0010; note_arr[1] = 7'h21;
        tick();
        req = '0;
        tick();
        chk("drop_ack", ack, 4'b0010);
        chk("drop_valid", freq_valid, 1);
        tick();
        chk("drop_busy", busy, 0);

        // reset during LOOKUP aborts, then arbitration restarts at ptr 0
        req = 4'b0001; note_arr[0] = 7'h50;
        tick();
        rst_n = 1'b0;
        tick();
        chk("rmid_ack", ack, 0);
        chk("rmid_valid", freq_valid, 0);
        chk("rmid_freq", freq_out, 0);
        chk("rmid_id", freq_id, 0);
        chk("rmid_lut", lut_note, 0);
        chk("rmid_busy", busy, 0);
        rst_n = 1'b1; req = 4'b1000; note_arr[3] = 7'h10;
        tick();
        chk("rmid_grant_note", lut_note, 7'h10);
        tick();
        chk("rmid_ack3", ack, 4'b1000);
        chk("rmid_id3", freq_id, 3);
        req = 4'b1001;
        tick();
        tick();
        tick();
        chk("wrap_ack0", ack, 4'b0001);
        req = '0;
        tick();

        // fairness with all requesters held
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        req = 4'b1111;
        note_arr = {7'h3C, 7'h40, 7'h44, 7'h48};
        acks_seen = 0;
        for (int c = 0; c < 15; c++) begin
            tick();
            if (ack != '0 && acks_seen < 5) begin
                for (int i = 0; i < N; i++) if (ack[i]) ack_who[acks_seen] = i;
                ack_cyc[acks_seen] = c;
                acks_seen++;
            end
        end
        chk("fair_count", acks_seen, 5);
        for (int j = 0; j < 5 && j < acks_seen; j++) begin
            chk("fair_order", ack_who[j], j % N);
            if (j > 0) chk("fair_space", ack_cyc[j] - ack_cyc[j-1], 3);
        end
        req = '0;
        tick();

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            for (int i = 0; i < N; i++) begin
                if (req[i]) begin
                    if (exp_ack[i] && $urandom_range(0, 3) != 0) req[i] = 1'b0;
                    if ($urandom_range(0, 7) == 0) note_arr[i] = NW'($urandom);
                end else if ($urandom_range(0, 3) == 0) begin
                    req[i] = 1'b1;
                    note_arr[i] = NW'($urandom);
                end
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
